// File: rtl/cpu_exec_ctrl_if.sv
// cpu_exec_ctrl_if
//   Bus between the execution sequencer and the CPU / front panel.
//   master modport : the sequencer (drives cpu_ce, state, instr_cnt)
//   slave  modport : the CPU side (drives div_sel, pc, bp_addr, bp_valid)
//   Signals:
//     div_sel   [1:0]  run rate select, period = DIV_BASE << (2*div_sel)
//     pc        [3:0]  ip of the instruction about to execute
//     bp_addr   [3:0]  breakpoint address
//     bp_valid         breakpoint armed
//     cpu_ce           one-cycle execute enable to the CPU
//     state     [1:0]  00 HALT, 01 RUN, 10 STEP, 11 BREAK
//     instr_cnt [7:0]  number of cpu_ce pulses issued, wrapping
interface cpu_exec_ctrl_if;
  logic [1:0] div_sel;
  logic [3:0] pc;
  logic [3:0] bp_addr;
  logic       bp_valid;
  logic       cpu_ce;
  logic [1:0] state;
  logic [7:0] instr_cnt;

  modport master (
    input  div_sel, pc, bp_addr, bp_valid,
    output cpu_ce, state, instr_cnt
  );

  modport slave (
    output div_sel, pc, bp_addr, bp_valid,
    input  cpu_ce, state, instr_cnt
  );
endinterface

// File: rtl/cpu_exec_ctrl.sv
// cpu_exec_ctrl
//   Execution sequencer for the 4-bit CPU. Produces the CPU clock enable so the
//   program free-runs at a slow visible rate, single-steps on a button, or halts.
//   Optional build macro CPU_EXEC_CTRL_BREAKPOINT_EN adds an address breakpoint
//   that stops free-run before the instruction at bp_addr.
//   Ports:
//     clk       system clock
//     n_reset   asynchronous active-low reset
//     btn_run   raw run/halt toggle button, active-high, asynchronous
//     btn_step  raw single-step button, active-high, asynchronous
//     bus       cpu_exec_ctrl_if.master (div_sel, pc, bp_addr, bp_valid in;
//               cpu_ce, state, instr_cnt out)
module cpu_exec_ctrl #(
  parameter logic [23:0] DIV_BASE  = 24'd3_000_000,
  parameter int unsigned DIV_W     = 32,
  parameter logic [15:0] DB_CYCLES = 16'd60_000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic btn_run,
  input  logic btn_step,
  cpu_exec_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

  // Button conditioning: index 0 = run, index 1 = step.
  logic [1:0]  btn_raw;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic [1:0]  db_level;
  logic [1:0]  btn_pulse;
  logic [15:0] db_cnt [2];

  assign btn_raw = {btn_step, btn_run};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1     <= '0;
      sync2     <= '0;
      db_level  <= '0;
      btn_pulse <= '0;
      // NOTE: this tiny counter array is plain flops, so each entry is reset;
      // a real RAM would not be.
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CYCLES - 16'd1) begin
          // DB_CYCLES consecutive differing samples: accept the new level and
          // emit a single pulse on the accepted rising edge.
          db_level[i]  <= sync2[i];
          db_cnt[i]    <= '0;
          btn_pulse[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  logic run_pulse;
  logic step_pulse;
  assign run_pulse  = btn_pulse[0];
  assign step_pulse = btn_pulse[1];

  // Sequencer
  state_e           state_q;
  logic             ce_q;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] period_next;
  logic             terminal;
  logic             bp_hit;
  logic [7:0]       instr_cnt_q;

  assign period_next = DIV_W'(DIV_BASE) << {bus.div_sel, 1'b0};
  assign terminal    = (presc_q == period_q - DIV_W'(1));

`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
  // Set when resuming from BREAK so the instruction under the breakpoint runs.
  logic skip_q;
  assign bp_hit = bus.bp_valid && (bus.pc == bus.bp_addr) && !skip_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bus.bp_valid, bus.bp_addr, bus.pc};
  assign bp_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= ST_HALT;
      ce_q     <= 1'b0;
      presc_q  <= '0;
      period_q <= DIV_W'(DIV_BASE);
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
      skip_q   <= 1'b0;
`endif
    end else begin
      ce_q <= 1'b0;
      case (state_q)
        ST_HALT: begin
          // run_pulse has priority; a coincident step_pulse is dropped.
          if (run_pulse) begin
            state_q  <= ST_RUN;
            presc_q  <= '0;
            period_q <= period_next;
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
            skip_q   <= 1'b0;
`endif
          end else if (step_pulse) begin
            state_q <= ST_STEP;
            ce_q    <= 1'b1;
          end
        end
        ST_STEP: begin
          state_q <= ST_HALT;
        end
        ST_RUN: begin
          if (run_pulse) begin
            // Halting wins over a coincident terminal count: no ce issued.
            state_q <= ST_HALT;
            presc_q <= '0;
          end else if (terminal) begin
            presc_q  <= '0;
            period_q <= period_next;
            if (bp_hit) begin
              state_q <= ST_BREAK;
            end else begin
              ce_q <= 1'b1;
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
              skip_q <= 1'b0;
`endif
            end
          end else begin
            presc_q <= presc_q + DIV_W'(1);
          end
        end
`ifdef CPU_EXEC_CTRL_BREAKPOINT_EN
        ST_BREAK: begin
          if (run_pulse) begin
            state_q  <= ST_RUN;
            presc_q  <= '0;
            period_q <= period_next;
            skip_q   <= 1'b1;
          end else if (step_pulse) begin
            state_q <= ST_STEP;
            ce_q    <= 1'b1;
            skip_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      instr_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_q + 8'(ce_q);
    end
  end

  assign bus.cpu_ce    = ce_q;
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule
